// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back arbiter for the register file's single write port.
// Source A (single-cycle ALU results) has priority. Source B (long-latency
// results) is queued in a small FIFO. A starvation counter forces the B head out
// when it has been stalled for STARVE_MAX consecutive cycles.
// Optional feature macro: WB_STATS_EN adds saturating wb_count/starve_count outputs.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        RegWrite,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
`ifdef WB_STATS_EN
  ,
  output logic [31:0] wb_count,
  output logic [15:0] starve_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [SW-1:0] scnt_reg;
  logic [36:0]   mem [DEPTH];

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          force_b;
  logic [36:0]   head;
  logic          win_valid;
  logic [4:0]    win_addr;
  logic [31:0]   win_data;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  // b_ready depends only on the registered full flag, so a same-cycle pop
  // never opens room for a push.
  assign b_ready = !full;
  assign push    = b_valid && !full;
  assign head    = mem[rd_ptr_reg[AW-1:0]];
  assign force_b = (scnt_reg == SMAX) && !empty;
  assign a_ready = !force_b;

  // Choose the winner for this cycle: forced B, then A, then any queued B.
  always_comb begin
    pop       = 1'b0;
    win_valid = 1'b0;
    win_addr  = a_addr;
    win_data  = a_data;
    if (force_b) begin
      pop       = 1'b1;
      win_valid = 1'b1;
      win_addr  = head[36:32];
      win_data  = head[31:0];
    end else if (a_valid) begin
      win_valid = 1'b1;
    end else if (!empty) begin
      pop       = 1'b1;
      win_valid = 1'b1;
      win_addr  = head[36:32];
      win_data  = head[31:0];
    end
  end

  // FIFO storage; entries need no reset because the pointers define validity.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {b_addr, b_data};
    end
  end

  // FIFO pointers; reset discards all queued entries.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // Starvation counter: counts consecutive cycles the B head waits unserved.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scnt_reg <= '0;
    end else if (pop || empty) begin
      scnt_reg <= '0;
    end else if (scnt_reg != SMAX) begin
      scnt_reg <= scnt_reg + SW'(1);
    end
  end

  // Registered commit; writes to x0 are consumed silently, idle holds addr/data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      RegWrite <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else if (win_valid && (win_addr != 5'd0)) begin
      RegWrite <= 1'b1;
      waddr    <= win_addr;
      wdata    <= win_data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

`ifdef WB_STATS_EN
  // Saturating statistics: committed writes and forced-B cycles.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wb_count     <= '0;
      starve_count <= '0;
    end else begin
      if (RegWrite && (wb_count != 32'hFFFF_FFFF)) wb_count <= wb_count + 32'd1;
      if (force_b && (starve_count != 16'hFFFF))   starve_count <= starve_count + 16'd1;
    end
  end
`endif

endmodule
